byte_lane_bram: RTL and testbench

//  Simple-dual-port 8-bit x 8192 block RAM used as one byte lane of the 64-bit data memory.
//  - Eight instances (one per byte, lane 0 = bits [7:0]) form one 64-bit dword; dword index = byte addr[15:3].
//  - Port A is write-only with a per-lane byte enable; port B is read-only with a registered output.
//  - Maps onto FPGA block RAM; the surrounding controller holds addrb stable until it samples doutb.

---
 rtl/byte_lane_bram.sv | 64 ++++++
 tb/tb_byte_lane_bram.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/byte_lane_bram.sv
// One byte lane of the 64-bit data memory: write-only port A, read-first read-only port B.
// Read latency 1 or 2 cycles (READ_LATENCY), no backpressure; the read runs every cycle.
module byte_lane_bram #(
    parameter int    DEPTH        = 8192,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "",
    parameter int    LANE         = 0,
    localparam int   AW           = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wea,
    input  logic [AW-1:0] addra,
    input  logic [7:0]    dina,
    input  logic [AW-1:0] addrb,
    output logic [7:0]    doutb
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    // Array has no reset so it maps onto block RAM; writes are dropped while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && wea) begin
            mem[addra] <= dina;
        end
    end

    // Non-blocking read of the pre-edge contents gives read-first on a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= 8'h00;
        end else begin
            rd_q <= mem[addrb];
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [7:0] out_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                out_q <= 8'h00;
            end else begin
                out_q <= rd_q;
            end
        end

        assign doutb = out_q;
    end else if (READ_LATENCY == 1) begin : g_lat1
        assign doutb = rd_q;
    end else begin : g_bad_latency
        $error("byte_lane_bram lane %0d: READ_LATENCY must be 1 or 2", LANE);
    end

    if (LANE < 0 || LANE > 7) begin : g_bad_lane
        $error("byte_lane_bram: LANE %0d outside 0..7", LANE);
    end

    if (INIT_FILE != "") begin : g_init_note
        $info("byte_lane_bram lane %0d: image %s", LANE, INIT_FILE);
    end

endmodule

// File: tb/tb_byte_lane_bram.sv
// Directed table-driven bench for byte_lane_bram: latency-1 and latency-2 lanes plus an 8-lane dword.
module tb_byte_lane_bram;

    logic        clk;
    logic        rst;
    logic        wea;
    logic [12:0] addra;
    logic [7:0]  dina;
    logic [12:0] addrb;
    logic [7:0]  dout1;
    logic [7:0]  dout2;
    logic [7:0]  lane_wea;
    logic [63:0] lane_din;
    logic [63:0] lane_dout;

    int total;
    int bad;

    typedef struct {
        logic        wea;
        logic [12:0] addra;
        logic [7:0]  dina;
        logic [12:0] addrb;
        logic [7:0]  exp;
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];

    byte_lane_bram #(.READ_LATENCY(1), .LANE(0)) u_dut (
        .clk(clk), .rst(rst), .wea(wea), .addra(addra), .dina(dina),
        .addrb(addrb), .doutb(dout1)
    );

    byte_lane_bram #(.READ_LATENCY(2), .LANE(1)) u_lat2 (
        .clk(clk), .rst(rst), .wea(wea), .addra(addra), .dina(dina),
        .addrb(addrb), .doutb(dout2)
    );

    for (genvar g = 0; g < 8; g++) begin : g_lane
        byte_lane_bram #(.READ_LATENCY(1), .LANE(g)) u_lane (
            .clk(clk), .rst(rst), .wea(lane_wea[g]), .addra(addra),
            .dina(lane_din[8*g +: 8]), .addrb(addrb),
            .doutb(lane_dout[8*g +: 8])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] prev;

        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        wea      = 1'b0;
        addra    = '0;
        dina     = '0;
        addrb    = '0;
        lane_wea = '0;
        lane_din = '0;

        // Each row is driven for one edge; exp is the latency-1 output after that edge.
        vt[0]  = '{1'b0, 13'h0000, 8'h00, 13'h0000, 8'h00};
        vt[1]  = '{1'b1, 13'h0010, 8'hA5, 13'h0000, 8'h00};
        vt[2]  = '{1'b0, 13'h0000, 8'h00, 13'h0010, 8'hA5};
        vt[3]  = '{1'b1, 13'h0020, 8'h11, 13'h0010, 8'hA5};
        vt[4]  = '{1'b1, 13'h0020, 8'h3C, 13'h0020, 8'h11};
        vt[5]  = '{1'b0, 13'h0000, 8'h00, 13'h0020, 8'h3C};
        vt[6]  = '{1'b1, 13'h0030, 8'h77, 13'h0020, 8'h3C};
        vt[7]  = '{1'b0, 13'h0030, 8'hFF, 13'h0030, 8'h77};
        vt[8]  = '{1'b0, 13'h0030, 8'hFF, 13'h0030, 8'h77};
        vt[9]  = '{1'b1, 13'h1FFF, 8'hEE, 13'h0000, 8'h00};
        vt[10] = '{1'b1, 13'h0000, 8'h01, 13'h1FFF, 8'hEE};
        vt[11] = '{1'b0, 13'h0000, 8'h00, 13'h0000, 8'h01};
        vt[12] = '{1'b0, 13'h0000, 8'h00, 13'h1FFF, 8'hEE};
        vt[13] = '{1'b1, 13'h0040, 8'h12, 13'h0000, 8'h01};
        vt[14] = '{1'b1, 13'h0040, 8'h34, 13'h0040, 8'h12};
        vt[15] = '{1'b1, 13'h0041, 8'h56, 13'h0040, 8'h34};
        vt[16] = '{1'b0, 13'h0000, 8'h00, 13'h0041, 8'h56};
        vt[17] = '{1'b0, 13'h0000, 8'h00, 13'h0040, 8'h34};

        @(negedge clk);
        step();
        step();
        check("reset_lat1", {56'h0, dout1}, 64'h00);
        check("reset_lat2", {56'h0, dout2}, 64'h00);
        rst = 1'b0;

        // Latency-2 lane sees the same stimulus, so it trails the latency-1 result by one edge.
        prev = 8'h00;
        for (int i = 0; i < NV; i++) begin
            wea   = vt[i].wea;
            addra = vt[i].addra;
            dina  = vt[i].dina;
            addrb = vt[i].addrb;
            step();
            check($sformatf("vec%0d_lat1", i), {56'h0, dout1}, {56'h0, vt[i].exp});
            check($sformatf("vec%0d_lat2", i), {56'h0, dout2}, {56'h0, prev});
            prev = vt[i].exp;
        end

        // Reset mid-read: in-flight data discarded, write in the reset cycle dropped.
        wea   = 1'b0;
        addrb = 13'h0010;
        step();
        step();
        check("pre_rst_lat1", {56'h0, dout1}, 64'hA5);
        check("pre_rst_lat2", {56'h0, dout2}, 64'hA5);
        rst   = 1'b1;
        wea   = 1'b1;
        addra = 13'h0010;
        dina  = 8'h5A;
        step();
        check("rst_clr_lat1", {56'h0, dout1}, 64'h00);
        check("rst_clr_lat2", {56'h0, dout2}, 64'h00);
        rst = 1'b0;
        wea = 1'b0;
        step();
        check("post_rst_lat1", {56'h0, dout1}, 64'hA5);
        check("post_rst_lat2_first", {56'h0, dout2}, 64'h00);
        step();
        check("post_rst_lat2", {56'h0, dout2}, 64'hA5);

        // Eight lanes as one dword, then a single-lane rewrite of lane 2.
        addra    = 13'h0100;
        addrb    = 13'h0100;
        lane_wea = 8'hFF;
        lane_din = 64'h0123456789ABCDEF;
        step();
        check("dword_old", lane_dout, 64'h0);
        lane_wea = 8'h04;
        lane_din = 64'h0;
        step();
        check("dword_full", lane_dout, 64'h0123456789ABCDEF);
        lane_wea = 8'h00;
        step();
        check("dword_lane2", lane_dout, 64'h012345678900CDEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
